// File: rtl/sync_fifo_axis_packetizer.sv
`timescale 1ns/1ps
// Read-side packetizer for sync_fifo: drains a first-word-fall-through FIFO into
// AXI-Stream packets of programmable length, flushing residual words on timeout.
module sync_fifo_axis_packetizer #(
    parameter int DWIDTH  = 32,
    parameter int DEPTH   = 512,
    parameter int TIMEOUT = 256,
    localparam int W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      pkt_len,
    input  logic [DWIDTH-1:0] fifo_rd_data,
    input  logic              fifo_rd_empty,
    input  logic [W-1:0]      fifo_cnt,
    output logic              fifo_rd_en,
    output logic [DWIDTH-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    output logic              busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam int            TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [W-1:0]  DEPTH_W  = W'(DEPTH);

    logic [1:0]        state;
    logic [W-1:0]      words_left;
    logic [W-1:0]      eff_len;
    logic              short_pkt;
    logic [TW-1:0]     tmo_cnt;
    logic [1:0]        occ;
    logic [DWIDTH-1:0] head_data;
    logic [DWIDTH-1:0] tail_data;
    logic              head_last;
    logic              head_user;
    logic              tail_last;
    logic              tail_user;
    logic              in_last;
    logic              full_ready;
    logic              residual;
    logic              flush;
    logic              push;
    logic              pop;

    always_comb begin
        if (pkt_len == '0)
            eff_len = W'(1);
        else if (pkt_len > DEPTH_W)
            eff_len = DEPTH_W;
        else
            eff_len = pkt_len;
    end

    assign full_ready = (fifo_cnt >= eff_len);
    assign residual   = (fifo_cnt != '0) && (fifo_cnt < eff_len);
    assign flush      = (TIMEOUT != 0) && residual && (tmo_cnt == TMO_LAST);

    // Read enable depends only on registered state and the FIFO flag, never on tready.
    assign fifo_rd_en = (state == SEND) && (words_left != '0) && !fifo_rd_empty && (occ != 2'd2);
    assign in_last    = (words_left == W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            words_left <= '0;
            short_pkt  <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (full_ready) begin
                        state      <= SEND;
                        words_left <= eff_len;
                        short_pkt  <= 1'b0;
                        tmo_cnt    <= '0;
                    end else if (flush) begin
                        state      <= SEND;
                        words_left <= fifo_cnt;
                        short_pkt  <= 1'b1;
                        tmo_cnt    <= '0;
                    end else if (residual) begin
                        if (tmo_cnt != '1)
                            tmo_cnt <= tmo_cnt + 1'b1;
                    end else begin
                        tmo_cnt <= '0;
                    end
                end
                SEND: begin
                    tmo_cnt <= '0;
                    if (fifo_rd_en) begin
                        words_left <= words_left - 1'b1;
                        if (in_last)
                            state <= GAP;
                    end
                end
                GAP: begin
                    // One idle cycle so the lagging fifo_cnt reflects the final read.
                    tmo_cnt <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign push = fifo_rd_en;
    assign pop  = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ       <= 2'd0;
            head_data <= '0;
            head_last <= 1'b0;
            head_user <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
            tail_user <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_data <= fifo_rd_data;
                        head_last <= in_last;
                        head_user <= short_pkt;
                    end else begin
                        tail_data <= fifo_rd_data;
                        tail_last <= in_last;
                        tail_user <= short_pkt;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head_data <= tail_data;
                    head_last <= tail_last;
                    head_user <= tail_user;
                    occ       <= occ - 2'd1;
                end
                2'b11: begin
                    // Push needs occ < 2 and pop needs occ > 0, so occ is 1 here.
                    head_data <= fifo_rd_data;
                    head_last <= in_last;
                    head_user <= short_pkt;
                end
                default: ;
            endcase
        end
    end

    assign m_axis_tdata  = head_data;
    assign m_axis_tvalid = (occ != 2'd0);
    assign m_axis_tlast  = head_last;
    assign m_axis_tuser  = head_user;
    assign busy          = (state != IDLE) || (occ != 2'd0);

endmodule
